inst_fetch: RTL

INST_FETCH -- requirements
Module: inst_fetch

---
 rtl/inst_fetch.sv | 126 ++++++++++++
 1 files changed

// File: rtl/inst_fetch.sv
`default_nettype none
// ============================================================================
// Module      : inst_fetch
// Description : Three-phase instruction fetch unit (FETCH -> WAIT -> HOLD)
//               with valid/ready hand-off, redirect and halt-opcode stop.
//               Optional delivered-instruction counter under the macro
//               FETCH_PERF_CNT_EN (otherwise fetch_count is tied to zero).
// Revision    : 1.0 - initial release
// ============================================================================
module inst_fetch #(
    parameter logic [7:0] RESET_PC    = 8'h00,
    parameter logic [4:0] HALT_OPCODE = 5'h1F
) (
    input  logic        clk,
    input  logic        Reset,
    output logic [7:0]  mem_Address,
    output logic        mem_instRead,
    input  logic [24:0] mem_Dataout,
    input  logic [4:0]  mem_opcode,
    input  logic        redirect,
    input  logic [7:0]  redirect_addr,
    input  logic        fetch_ready,
    output logic        fetch_valid,
    output logic [24:0] fetch_inst,
    output logic [7:0]  fetch_pc,
    output logic        halted,
    output logic [15:0] fetch_count
);

    localparam logic [1:0] S_FETCH = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;
    localparam logic [1:0] S_HALT  = 2'd3;

    logic [1:0]  state_q,  state_d;
    logic [7:0]  pc_q,     pc_d;
    logic        valid_q,  valid_d;
    logic [24:0] inst_q,   inst_d;
    logic [7:0]  fpc_q,    fpc_d;
    logic        is_halt_q, is_halt_d;   // held word carries the halt opcode

    // Next-state logic; redirect overrides every other transition
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        valid_d   = valid_q;
        inst_d    = inst_q;
        fpc_d     = fpc_q;
        is_halt_d = is_halt_q;
        if (redirect) begin
            state_d = S_FETCH;
            pc_d    = redirect_addr;
            valid_d = 1'b0;
        end else begin
            case (state_q)
                S_FETCH: state_d = S_WAIT;
                S_WAIT: begin
                    inst_d    = mem_Dataout;
                    fpc_d     = pc_q;
                    valid_d   = 1'b1;
                    pc_d      = pc_q + 8'd1;      // natural 8-bit wrap
                    is_halt_d = (mem_opcode == HALT_OPCODE);
                    state_d   = S_HOLD;
                end
                S_HOLD: begin
                    if (fetch_ready) begin
                        valid_d = 1'b0;
                        state_d = is_halt_q ? S_HALT : S_FETCH;
                    end
                end
                S_HALT:  state_d = S_HALT;
                default: state_d = S_FETCH;
            endcase
        end
    end

    // State and fetch-output registers, asynchronously cleared by Reset
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state_q   <= S_FETCH;
            pc_q      <= RESET_PC;
            valid_q   <= 1'b0;
            inst_q    <= 25'b0;
            fpc_q     <= 8'b0;
            is_halt_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            valid_q   <= valid_d;
            inst_q    <= inst_d;
            fpc_q     <= fpc_d;
            is_halt_q <= is_halt_d;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic        w_accept;
    logic [15:0] count_q;

    // An instruction is accepted whenever HOLD sees ready, redirect or not
    assign w_accept = (state_q == S_HOLD) && fetch_ready;

    // Saturating count of accepted instructions
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            count_q <= 16'b0;
        end else if (w_accept && (count_q != 16'hFFFF)) begin
            count_q <= count_q + 16'd1;
        end
    end

    assign fetch_count = count_q;
`else
    assign fetch_count = 16'b0;
`endif

    // Reset masks the strobe because the state is forced to FETCH during it
    assign mem_instRead = (state_q == S_FETCH) && !Reset;
    assign mem_Address  = pc_q;
    assign fetch_valid  = valid_q;
    assign fetch_inst   = inst_q;
    assign fetch_pc     = fpc_q;
    assign halted       = (state_q == S_HALT);

endmodule
`default_nettype wire
